icache_axi_rd_bridge: RTL and testbench
=======================================

Name: icache_axi_rd_bridge

Overview:
- Slave end of the instruction-cache refill port: accepts one read request (rd_req/rd_addr/rd_uncache) and turns it into a single AXI4 read burst.
- Assembles the returned 32-bit beats into a 128-bit ret_data and returns it with a one-cycle ret_valid pulse.
- Sits between the icache and the AXI interconnect; only one transaction is outstanding at a time.

Parameters:
- AXI_ID, 4'd0, constant arid driven on every request.
- LINE_BEATS, 4, beats per cached line refill (128/32).
- UNC_BEATS, 2, beats per uncached fetch (64 bits).

Ports:
- clk_g  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- rd_req  in  1  refill/fetch request, held until rd_rdy
- rd_addr  in  32  request address
- rd_uncache  in  1  1 = uncached fetch, 0 = cached line refill
- rd_rdy  out  1  request accepted this cycle
- ret_valid  out  1  one-cycle pulse: ret_data valid
- ret_data  out  128  assembled read data
- ret_err  out  1  valid with ret_valid: any rresp != OKAY, or rid/rlast mismatch
- arid  out  4  = AXI_ID
- araddr  out  32  burst address
- arlen  out  8  beats-1
- arsize  out  3  fixed 3'b010
- arburst  out  2  fixed 2'b01 (INCR)
- arcache  out  4  cached 4'b0011, uncached 4'b0000
- arprot  out  3  fixed 3'b100 (instruction)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R id
- rdata  in  32  R data
- rresp  in  2  R response
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- States: IDLE -> AR -> RDATA -> DONE -> IDLE.
- Reset (async, any state): state=IDLE; arvalid=0, rready=0, ret_valid=0, ret_err=0, ret_data=0, beat count=0, latched addr/uncache=0. An in-flight AXI transaction is abandoned; the interconnect is reset together with this block.
- IDLE:
  - rd_rdy = 1 (combinational, IDLE only).
  - rd_req=1 accepts: latch rd_addr and rd_uncache, clear beat count and err, go to AR.
  - rd_rdy is 0 in every other state.
- Address and length latched at accept:
  - cached: araddr = {rd_addr[31:4], 4'b0}, arlen = LINE_BEATS-1 = 3.
  - uncached: araddr = {rd_addr[31:3], 3'b0}, arlen = UNC_BEATS-1 = 1.
- AR:
  - arvalid=1; araddr/arlen/arcache stay stable while arvalid=1 and arready=0.
  - arvalid&&arready -> RDATA; arvalid drops the next cycle.
- RDATA:
  - rready=1.
  - Each beat (rvalid&&rready): ret_data <= {rdata, ret_data[127:32]}; count++.
  - After 4 cached beats, beat0 sits in [31:0] and beat3 in [127:96].
  - After 2 uncached beats, beat0 sits in [95:64] and beat1 in [127:96], which the icache uncached path consumes.
- Error conditions (each sets sticky err for the transaction):
  - rresp != 2'b00 on any beat;
  - rid != AXI_ID;
  - rlast on a beat that is not beat arlen;
  - rlast=0 on beat arlen.
- Completion:
  - Leave RDATA on the first beat with rlast=1, or on beat arlen+1 if rlast never arrived. The counter is 3 bits and saturates.
  - A late rlast still needs no extra beats; later stray beats are not accepted because rready=0 outside RDATA.
- DONE (exactly 1 cycle):
  - ret_valid=1, ret_err=err, then IDLE.
  - ret_data holds its value until the next accepted beat.
- Timing:
  - Latency from rd_req&&rd_rdy to ret_valid = 1 (AR) + AR stall cycles + beats + R stall cycles + 1.
  - Minimum: 6 cycles cached, 4 cycles uncached.
- Simultaneous events:
  - rd_req in DONE is not accepted until IDLE the following cycle.
  - rvalid asserted during AR is ignored (rready=0).

Test Plan:
- Cached refill: rd_addr=0x1FC0_0A38, rd_uncache=0, arready=1, R beats 0x11,0x22,0x33,0x44 with rlast on beat 4 -> araddr=0x1FC0_0A30, arlen=3, arcache=4'b0011; ret_valid pulses for one cycle 6 cycles after accept; ret_data=0x00000044_00000033_00000022_00000011; ret_err=0.
- Uncached fetch: rd_addr=0xBFC0_0004, rd_uncache=1, beats 0xAAAA_AAAA then 0xBBBB_BBBB -> araddr=0xBFC0_0000, arlen=1, arcache=0; ret_data[127:64]=0xBBBBBBBB_AAAAAAAA.
- Backpressure: arready low for 5 cycles, then rvalid toggled 1/0 -> araddr/arlen stable while stalled; arvalid high until the handshake; exactly 4 beats captured; one ret_valid pulse.
- Error response: beat 2 has rresp=2'b10 -> all 4 beats still consumed; ret_err=1 alongside ret_valid; the next clean transaction returns ret_err=0.
- Early rlast: cached burst with rlast on beat 2 -> completes after 2 beats with ret_err=1; rready=0 in the cycle after DONE.
- Async reset: assert resetn=0 in RDATA after 2 beats, mid-cycle -> arvalid, rready, ret_valid immediately 0 with no clock edge needed; after release, rd_rdy=1 and a new request completes normally.

Source files
------------

// File: rtl/icache_axi_rd_bridge_if.sv
// AXI4 read-address and read-data channels between the icache refill bridge
// and the interconnect. master = bridge side, slave = interconnect side.
interface icache_axi_rd_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Icache refill port to AXI4 read bridge: one request becomes one INCR burst,
// 32-bit beats are shifted into a 128-bit line returned with a one-cycle pulse.
module icache_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         LINE_BEATS = 4,
    parameter int         UNC_BEATS  = 2
) (
    input  logic                          clk_g,
    input  logic                          resetn,
    input  logic                          rd_req,
    input  logic [31:0]                   rd_addr,
    input  logic                          rd_uncache,
    output logic                          rd_rdy,
    output logic                          ret_valid,
    output logic [127:0]                  ret_data,
    output logic                          ret_err,
    output logic [1:0]                    dbg_state,
    icache_axi_rd_bridge_if.master        axi
);
    // Handshakes: a transfer happens on a rising clk_g edge where both valid
    // and ready are high; valid never waits on ready, and a master holds its
    // payload stable while valid is high and ready is low.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AR    = 2'd1,
        S_RDATA = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);
    localparam logic [7:0] UNC_LEN  = 8'(UNC_BEATS - 1);

    state_t        state_q, state_d;
    logic [31:0]   addr_q;
    logic          unc_q;
    logic [2:0]    cnt_q;
    logic          err_q;
    logic [127:0]  data_q;

    logic          accept;
    logic          beat;
    logic          last_idx_hit;
    logic          beat_err;
    logic [2:0]    last_idx;

    // Low address bits are dropped by the line/fetch alignment.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^rd_addr[2:0];

    assign accept       = (state_q == S_IDLE) && rd_req;
    assign beat         = (state_q == S_RDATA) && axi.rvalid;
    assign last_idx     = unc_q ? UNC_LEN[2:0] : LINE_LEN[2:0];
    assign last_idx_hit = (cnt_q == last_idx);
    assign beat_err     = (axi.rresp != 2'b00) || (axi.rid != AXI_ID) ||
                          (axi.rlast != last_idx_hit);

    always_ff @(posedge clk_g or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rd_req) state_d = S_AR;
            S_AR:    if (axi.arready) state_d = S_RDATA;
            // A missing rlast still ends the burst at the expected beat count.
            S_RDATA: if (beat && (axi.rlast || last_idx_hit)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_g or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            unc_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else if (accept) begin
            addr_q <= rd_uncache ? {rd_addr[31:3], 3'b000} : {rd_addr[31:4], 4'b0000};
            unc_q  <= rd_uncache;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (beat) begin
            data_q <= {axi.rdata, data_q[127:32]};
            cnt_q  <= (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
            if (beat_err) err_q <= 1'b1;
        end
    end

    assign rd_rdy      = (state_q == S_IDLE);
    assign ret_valid   = (state_q == S_DONE);
    assign ret_err     = (state_q == S_DONE) && err_q;
    assign ret_data    = data_q;
    assign dbg_state   = state_q;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = unc_q ? UNC_LEN : LINE_LEN;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arcache = unc_q ? 4'b0000 : 4'b0011;
    assign axi.arprot  = 3'b100;
    assign axi.arvalid = (state_q == S_AR);
    assign axi.rready  = (state_q == S_RDATA);
endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench for icache_axi_rd_bridge: an AXI slave driver per
// transaction, expected lines queued at request time and checked on ret_valid.
module tb_icache_axi_rd_bridge;
    logic         clk_g = 1'b0;
    logic         resetn = 1'b0;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_uncache;
    logic         rd_rdy;
    logic         ret_valid;
    logic [127:0] ret_data;
    logic         ret_err;
    logic [1:0]   dbg_state;

    icache_axi_rd_bridge_if axi_if ();

    icache_axi_rd_bridge dut (
        .clk_g      (clk_g),
        .resetn     (resetn),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_uncache (rd_uncache),
        .rd_rdy     (rd_rdy),
        .ret_valid  (ret_valid),
        .ret_data   (ret_data),
        .ret_err    (ret_err),
        .dbg_state  (dbg_state),
        .axi        (axi_if)
    );

    always #5 clk_g = ~clk_g;

    int unsigned cyc = 0;
    int          pulses = 0;
    always @(posedge clk_g) cyc <= cyc + 1;
    always @(posedge clk_g) if (resetn && ret_valid) pulses <= pulses + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] mask_q[$];
    logic         exp_err_q[$];

    logic [31:0] beat_data[4];
    logic [1:0]  beat_resp[4];
    logic [3:0]  beat_id[4];

    task automatic set_beats(input logic [31:0] d0, d1, d2, d3);
        beat_data[0] = d0; beat_data[1] = d1; beat_data[2] = d2; beat_data[3] = d3;
        for (int i = 0; i < 4; i++) begin
            beat_resp[i] = 2'b00;
            beat_id[i]   = 4'd0;
        end
    endtask

    // rlast_idx beyond the burst length means rlast is never asserted.
    // abort_after >= 0 pulls resetn low mid-cycle once that many beats are in.
    task automatic run_txn(input logic [31:0] addr, input logic unc, input int ar_stall,
                           input int rlast_idx, input logic gaps, input int abort_after,
                           input string name);
        logic [31:0]  exp_araddr;
        logic [7:0]   exp_len;
        logic [3:0]   exp_cache;
        logic [127:0] m, mk, got, held;
        logic         e;
        int           nb, acc, p0, lat_exp;
        exp_araddr = unc ? {addr[31:3], 3'b000} : {addr[31:4], 4'b0000};
        exp_len    = unc ? 8'd1 : 8'd3;
        exp_cache  = unc ? 4'b0000 : 4'b0011;
        nb = (rlast_idx < int'(exp_len) + 1) ? rlast_idx + 1 : int'(exp_len) + 1;
        e  = (rlast_idx != int'(exp_len));
        m  = '0;
        mk = '0;
        for (int i = 0; i < nb; i++) begin
            m  = {beat_data[i], m[127:32]};
            mk = {32'hFFFF_FFFF, mk[127:32]};
            if (beat_resp[i] != 2'b00 || beat_id[i] != 4'd0) e = 1'b1;
        end
        lat_exp = 1 + ar_stall + nb + (gaps ? nb : 0) + 1;
        p0 = pulses;

        @(posedge clk_g); #1;
        rd_req = 1'b1; rd_addr = addr; rd_uncache = unc; axi_if.arready = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_g);
            if (rd_rdy) break;
        end
        n_checks++;
        if (rd_rdy !== 1'b1) $display("FAIL %s accept: rd_rdy=%b want 1", name, rd_rdy);
        else n_pass++;
        acc = int'(cyc);
        @(posedge clk_g); #1;
        rd_req = 1'b0; rd_addr = $urandom; rd_uncache = ~unc;

        for (int s = 0; s < ar_stall; s++) begin
            axi_if.rvalid = 1'b1; axi_if.rdata = $urandom; axi_if.rlast = 1'b1;
            axi_if.rresp = 2'b11;
            @(negedge clk_g);
            n_checks++;
            if (axi_if.arvalid !== 1'b1 || axi_if.araddr !== exp_araddr ||
                axi_if.arlen !== exp_len || axi_if.arcache !== exp_cache || axi_if.rready !== 1'b0)
                $display("FAIL %s ar_stall: arvalid=%b araddr=%h arlen=%0d rready=%b want 1 %h %0d 0",
                         name, axi_if.arvalid, axi_if.araddr, axi_if.arlen, axi_if.rready,
                         exp_araddr, exp_len);
            else n_pass++;
            @(posedge clk_g); #1;
        end
        axi_if.rvalid = 1'b0; axi_if.rresp = 2'b00; axi_if.rlast = 1'b0;
        axi_if.arready = 1'b1;
        @(negedge clk_g);
        n_checks++;
        if (axi_if.arvalid !== 1'b1 || axi_if.araddr !== exp_araddr || axi_if.arlen !== exp_len ||
            axi_if.arcache !== exp_cache || axi_if.arsize !== 3'b010 || axi_if.arburst !== 2'b01 ||
            axi_if.arprot !== 3'b100 || axi_if.arid !== 4'd0)
            $display("FAIL %s ar_fields: arvalid=%b araddr=%h arlen=%0d arcache=%b want 1 %h %0d %b",
                     name, axi_if.arvalid, axi_if.araddr, axi_if.arlen, axi_if.arcache,
                     exp_araddr, exp_len, exp_cache);
        else n_pass++;
        @(posedge clk_g); #1;
        axi_if.arready = 1'b0;

        if (abort_after < 0) begin
            exp_q.push_back(m);
            mask_q.push_back(mk);
            exp_err_q.push_back(e);
        end

        for (int i = 0; i < nb; i++) begin
            if (i == abort_after) begin
                #3;
                resetn = 1'b0;
                #1;
                n_checks++;
                if (axi_if.arvalid !== 1'b0 || axi_if.rready !== 1'b0 || ret_valid !== 1'b0 ||
                    dbg_state !== 2'd0 || ret_data !== 128'd0)
                    $display("FAIL %s async_reset: arvalid=%b rready=%b ret_valid=%b state=%0d want 0 0 0 0",
                             name, axi_if.arvalid, axi_if.rready, ret_valid, dbg_state);
                else n_pass++;
                axi_if.rvalid = 1'b0;
                @(posedge clk_g); #1;
                resetn = 1'b1;
                return;
            end
            if (gaps) begin
                axi_if.rvalid = 1'b0;
                @(posedge clk_g); #1;
            end
            axi_if.rvalid = 1'b1; axi_if.rdata = beat_data[i]; axi_if.rresp = beat_resp[i];
            axi_if.rid = beat_id[i]; axi_if.rlast = (i == rlast_idx);
            @(negedge clk_g);
            n_checks++;
            if (axi_if.rready !== 1'b1 || axi_if.arvalid !== 1'b0)
                $display("FAIL %s r_phase beat %0d: rready=%b arvalid=%b want 1 0",
                         name, i, axi_if.rready, axi_if.arvalid);
            else n_pass++;
            @(posedge clk_g); #1;
        end
        axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0; axi_if.rresp = 2'b00; axi_if.rid = 4'd0;

        for (int t = 0; t < 20; t++) begin
            @(negedge clk_g);
            if (ret_valid) break;
        end
        n_checks++;
        if (ret_valid !== 1'b1) $display("FAIL %s ret_timeout: ret_valid=%b want 1", name, ret_valid);
        else n_pass++;
        n_checks++;
        if (int'(cyc) - acc !== lat_exp)
            $display("FAIL %s latency: got %0d want %0d", name, int'(cyc) - acc, lat_exp);
        else n_pass++;
        m  = exp_q.pop_front();
        mk = mask_q.pop_front();
        e  = exp_err_q.pop_front();
        got = ret_data & mk;
        n_checks++;
        if (got !== (m & mk) || ret_err !== e || rd_rdy !== 1'b0)
            $display("FAIL %s ret: data=%h err=%b rd_rdy=%b want %h %b 0",
                     name, got, ret_err, rd_rdy, m & mk, e);
        else n_pass++;
        held = ret_data;
        axi_if.rvalid = 1'b1; axi_if.rdata = 32'hDEAD_BEEF; axi_if.rlast = 1'b1;
        @(negedge clk_g);
        n_checks++;
        if (ret_valid !== 1'b0 || axi_if.rready !== 1'b0 || ret_data !== held ||
            pulses !== p0 + 1)
            $display("FAIL %s after_done: ret_valid=%b rready=%b held=%b pulses=%0d want 0 0 1 %0d",
                     name, ret_valid, axi_if.rready, ret_data === held, pulses - p0, 1);
        else n_pass++;
        axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0;
    endtask

    task automatic test_reset();
        rd_req = 1'b0; rd_addr = '0; rd_uncache = 1'b0;
        axi_if.arready = 1'b0; axi_if.rvalid = 1'b0; axi_if.rdata = '0;
        axi_if.rresp = 2'b00; axi_if.rlast = 1'b0; axi_if.rid = 4'd0;
        resetn = 1'b0;
        repeat (3) @(negedge clk_g);
        n_checks++;
        if (rd_rdy !== 1'b1 || axi_if.arvalid !== 1'b0 || axi_if.rready !== 1'b0 ||
            ret_valid !== 1'b0 || ret_err !== 1'b0 || ret_data !== 128'd0 || dbg_state !== 2'd0)
            $display("FAIL reset: rd_rdy=%b arvalid=%b rready=%b ret_valid=%b ret_err=%b data=%h",
                     rd_rdy, axi_if.arvalid, axi_if.rready, ret_valid, ret_err, ret_data);
        else n_pass++;
        @(posedge clk_g); #1;
        resetn = 1'b1;
    endtask

    task automatic test_cached();
        set_beats(32'h11, 32'h22, 32'h33, 32'h44);
        run_txn(32'h1FC0_0A38, 1'b0, 0, 3, 1'b0, -1, "cached");
        n_checks++;
        if (ret_data !== 128'h00000044_00000033_00000022_00000011)
            $display("FAIL cached_line: got %h want %h", ret_data,
                     128'h00000044_00000033_00000022_00000011);
        else n_pass++;
    endtask

    task automatic test_uncached();
        set_beats(32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0, 32'h0);
        run_txn(32'hBFC0_0004, 1'b1, 0, 1, 1'b0, -1, "uncached");
        n_checks++;
        if (ret_data[127:64] !== 64'hBBBBBBBB_AAAAAAAA)
            $display("FAIL uncached_upper: got %h want %h", ret_data[127:64], 64'hBBBBBBBB_AAAAAAAA);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        set_beats(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10);
        run_txn(32'h8000_1234, 1'b0, 5, 3, 1'b1, -1, "backpressure");
    endtask

    task automatic test_error_resp();
        set_beats(32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004);
        beat_resp[1] = 2'b10;
        run_txn(32'h0000_0040, 1'b0, 1, 3, 1'b0, -1, "slverr");
        set_beats(32'h5, 32'h6, 32'h7, 32'h8);
        run_txn(32'h0000_0050, 1'b0, 0, 3, 1'b0, -1, "clean_after_err");
        set_beats(32'h9, 32'hA, 32'hB, 32'hC);
        beat_id[2] = 4'd5;
        run_txn(32'h0000_0060, 1'b0, 0, 3, 1'b0, -1, "bad_rid");
    endtask

    task automatic test_rlast_errors();
        set_beats(32'hE1, 32'hE2, 32'hE3, 32'hE4);
        run_txn(32'h1000_0000, 1'b0, 0, 1, 1'b0, -1, "early_rlast");
        set_beats(32'hF1, 32'hF2, 32'hF3, 32'hF4);
        run_txn(32'h1000_0010, 1'b0, 0, 99, 1'b0, -1, "missing_rlast");
        set_beats(32'h71, 32'h72, 32'h73, 32'h74);
        run_txn(32'h1000_0020, 1'b1, 0, 99, 1'b1, -1, "unc_missing_rlast");
    endtask

    task automatic test_async_reset();
        set_beats(32'hAB01, 32'hAB02, 32'hAB03, 32'hAB04);
        run_txn(32'h2000_0000, 1'b0, 0, 3, 1'b0, 2, "async_reset");
        @(negedge clk_g);
        n_checks++;
        if (rd_rdy !== 1'b1 || dbg_state !== 2'd0)
            $display("FAIL reset_release: rd_rdy=%b state=%0d want 1 0", rd_rdy, dbg_state);
        else n_pass++;
        set_beats(32'h1111, 32'h2222, 32'h3333, 32'h4444);
        run_txn(32'h2000_0010, 1'b0, 0, 3, 1'b0, -1, "after_reset");
    endtask

    task automatic test_random();
        logic unc;
        for (int k = 0; k < 8; k++) begin
            set_beats($urandom, $urandom, $urandom, $urandom);
            for (int i = 0; i < 4; i++) beat_resp[i] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            unc = 1'($urandom_range(0, 1));
            run_txn($urandom, unc, $urandom_range(0, 3), unc ? 1 : 3,
                    1'($urandom_range(0, 1)), -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_cached();
        test_uncached();
        test_backpressure();
        test_error_resp();
        test_rlast_errors();
        test_async_reset();
        test_random();
        repeat (2) @(negedge clk_g);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
